grid_tx_framer: RTL



---
 rtl/grid_tx_framer.sv | 118 +++++++++++
 1 files changed

// File: rtl/grid_tx_framer.sv
// Packs one 128-bit packet per channel per 40-pixel slot into nibble lanes with video timing.
// Outputs are registered one clock behind the counters; each lane accepts only at cctr==3 of an active slot.
module grid_tx_framer #(
  parameter int NCHANNELS = 9,
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 48,
  parameter int H_SYNC    = 32,
  parameter int H_BP      = 80,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [128*NCHANNELS-1:0] din,
  input  logic [NCHANNELS-1:0]     din_valid,
  output logic [NCHANNELS-1:0]     din_ready,
  output logic [4*NCHANNELS-1:0]   pData,
  output logic                     vde,
  output logic                     hsync,
  output logic                     vsync,
  output logic [NCHANNELS-1:0]     hdr_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] C_H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] C_H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] C_HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] C_HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] C_V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] C_V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] C_VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] C_VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0]          r_hcnt;
  logic [VW-1:0]          r_vcnt;
  logic [5:0]             r_cctr;
  logic [127:0]           r_shreg [NCHANNELS];
  logic [4*NCHANNELS-1:0] r_pdata;
  logic                   r_vde;
  logic                   r_hsync;
  logic                   r_vsync;
  logic [NCHANNELS-1:0]   r_hdr_err;

  logic                   w_active;
  logic                   w_hs;
  logic                   w_vs;
  logic                   w_load;
  logic                   w_emit;
  logic [NCHANNELS-1:0]   w_hdr_zero;

  always_comb begin
    w_active = (r_hcnt < C_H_ACT) && (r_vcnt < C_V_ACT);
    w_hs     = (r_hcnt >= C_HS_BEG) && (r_hcnt < C_HS_END);
    w_vs     = (r_vcnt >= C_VS_BEG) && (r_vcnt < C_VS_END);
    w_load   = w_active && (r_cctr == 6'd3);
    w_emit   = w_active && (r_cctr >= 6'd4) && (r_cctr <= 6'd35);
    for (int n = 0; n < NCHANNELS; n++) begin
      w_hdr_zero[n] = (din[128*n+120 +: 8] == 8'h00);
    end
  end

  assign din_ready = din_valid & {NCHANNELS{w_load}};

  // H_ACTIVE is a whole number of slots, so cctr is always 39 at the last active pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
      r_cctr <= '0;
    end else begin
      if (r_hcnt == C_H_LAST) begin
        r_hcnt <= '0;
        r_vcnt <= (r_vcnt == C_V_LAST) ? '0 : r_vcnt + 1'b1;
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
      if (w_active && (r_cctr != 6'd39)) r_cctr <= r_cctr + 1'b1;
      else                               r_cctr <= '0;
    end
  end

  // Zero-header packets are consumed but never sent; an unloaded lane shifts out zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NCHANNELS; n++) r_shreg[n] <= '0;
      r_pdata   <= '0;
      r_vde     <= 1'b0;
      r_hsync   <= 1'b0;
      r_vsync   <= 1'b0;
      r_hdr_err <= '0;
    end else begin
      r_vde   <= w_active;
      r_hsync <= w_hs;
      r_vsync <= w_vs;
      for (int n = 0; n < NCHANNELS; n++) begin
        r_hdr_err[n]       <= din_ready[n] && w_hdr_zero[n];
        r_pdata[4*n +: 4]  <= w_emit ? r_shreg[n][127:124] : 4'h0;
        if (w_load)
          r_shreg[n] <= (din_ready[n] && !w_hdr_zero[n]) ? din[128*n +: 128] : '0;
        else if (w_emit)
          r_shreg[n] <= {r_shreg[n][123:0], 4'h0};
      end
    end
  end

  assign pData   = r_pdata;
  assign vde     = r_vde;
  assign hsync   = r_hsync;
  assign vsync   = r_vsync;
  assign hdr_err = r_hdr_err;

endmodule
